// File: rtl/conv_psum_accum_pkg.sv
// Shared constants and types for the conv partial-sum accumulation stage.
package conv_psum_accum_pkg;

  localparam int CONV16_WIDTH = 16;
  localparam int CONV_COLS    = 14;
  localparam int CONV_ACC_W   = 40;
  localparam int CONV_SHIFT_W = 5;

  typedef logic signed [CONV_ACC_W-1:0] conv_acc_t;

  typedef enum logic {ACCUM, DRAIN} psacc_state_e;

endpackage

// File: rtl/conv_psum_accum_requant.sv
// Combinational requantizer: round-half-up arithmetic right shift, optional ReLU,
// then saturation to a signed DW-bit result.
module conv_requant
  import conv_psum_accum_pkg::*;
#(
  parameter int DW  = CONV16_WIDTH,
  parameter int AW  = CONV_ACC_W,
  parameter int SHW = CONV_SHIFT_W
) (
  input  logic signed [AW-1:0]  x,
  input  logic        [SHW-1:0] shift,
  input  logic                  relu,
  output logic signed [DW-1:0]  y
);

  localparam logic signed [AW:0] MAX_V = {{(AW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW:0] MIN_V = {{(AW-DW+2){1'b1}}, {(DW-1){1'b0}}};

  // One guard bit so adding the rounding constant never wraps.
  logic signed [AW:0] x_ext;
  logic signed [AW:0] rounded;
  logic signed [AW:0] r;

  always_comb begin
    x_ext   = {x[AW-1], x};
    rounded = x_ext;
    if (shift != '0) begin
      rounded = x_ext + ((AW+1)'(1) << (shift - SHW'(1)));
    end
    r = rounded >>> shift;
    if (relu && r[AW]) begin
      r = '0;
    end
    if (r > MAX_V) begin
      y = MAX_V[DW-1:0];
    end else if (r < MIN_V) begin
      y = MIN_V[DW-1:0];
    end else begin
      y = r[DW-1:0];
    end
  end

endmodule

// File: rtl/conv_psum_accum.sv
// Accumulates per-column core sums across input channels, adds bias, and drains
// the requantized columns one word per handshake.
module conv_psum_accum
  import conv_psum_accum_pkg::*;
#(
  parameter int DW   = CONV16_WIDTH,
  parameter int NCOL = CONV_COLS,
  parameter int AW   = CONV_ACC_W,
  parameter int SHW  = CONV_SHIFT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_first,
  input  logic                     in_last,
  input  logic [NCOL*2*DW-1:0]     i_sum,
  input  logic signed [AW-1:0]     i_bias,
  input  logic [SHW-1:0]           i_shift,
  input  logic                     i_relu,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic signed [DW-1:0]     o_data,
  output logic [3:0]               o_idx,
  output logic                     o_last
);

  localparam logic [3:0] LAST_IDX = 4'(NCOL-1);

  psacc_state_e          state;
  logic signed [AW-1:0]  acc     [NCOL];
  logic signed [AW-1:0]  sum_ext [NCOL];
  logic [3:0]            idx;
  logic [SHW-1:0]        shift_q;
  logic                  relu_q;
  logic signed [DW-1:0]  rq_y;

  always_comb begin
    for (int k = 0; k < NCOL; k++) begin
      sum_ext[k] = AW'($signed(i_sum[k*2*DW +: 2*DW]));
    end
  end

  // in_ready/o_valid are registered alongside the state so they are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCUM;
      idx      <= '0;
      in_ready <= 1'b1;
      o_valid  <= 1'b0;
      shift_q  <= '0;
      relu_q   <= 1'b0;
      for (int k = 0; k < NCOL; k++) acc[k] <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            for (int k = 0; k < NCOL; k++) begin
              acc[k] <= (in_first ? i_bias : acc[k]) + sum_ext[k];
            end
            if (in_last) begin
              shift_q  <= i_shift;
              relu_q   <= i_relu;
              state    <= DRAIN;
              in_ready <= 1'b0;
              o_valid  <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (o_ready) begin
            if (idx == LAST_IDX) begin
              idx      <= '0;
              state    <= ACCUM;
              in_ready <= 1'b1;
              o_valid  <= 1'b0;
              for (int k = 0; k < NCOL; k++) acc[k] <= '0;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  conv_requant #(
    .DW  (DW),
    .AW  (AW),
    .SHW (SHW)
  ) u_requant (
    .x     (acc[idx]),
    .shift (shift_q),
    .relu  (relu_q),
    .y     (rq_y)
  );

  assign o_data = o_valid ? rq_y : '0;
  assign o_idx  = idx;
  assign o_last = o_valid && (idx == LAST_IDX);

endmodule

// File: tb/tb_conv_psum_accum.sv
// Scoreboard bench for conv_psum_accum: beats update a plain-arithmetic model,
// drains push expected words, and a negedge monitor pops and compares.
module tb_conv_psum_accum;
  import conv_psum_accum_pkg::*;

  localparam int DW = 16, NCOL = 14, AW = 40, SHW = 5;

  typedef int sums_t [NCOL];
  typedef struct {longint data; int idx; bit last;} exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 in_first = 1'b0;
  logic                 in_last = 1'b0;
  logic [NCOL*2*DW-1:0] i_sum = '0;
  logic signed [AW-1:0] i_bias = '0;
  logic [SHW-1:0]       i_shift = '0;
  logic                 i_relu = 1'b0;
  logic                 o_valid;
  logic                 o_ready = 1'b1;
  logic signed [DW-1:0] o_data;
  logic [3:0]           o_idx;
  logic                 o_last;

  int     tests_run = 0;
  int     tests_failed = 0;
  exp_t   q[$];
  longint macc [NCOL];
  bit     rnd_ready = 1'b0;
  bit     stalled = 1'b0;
  logic signed [DW-1:0] prev_data;
  logic [3:0]           prev_idx;
  exp_t   e;

  conv_psum_accum dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .i_sum(i_sum), .i_bias(i_bias),
    .i_shift(i_shift), .i_relu(i_relu), .o_valid(o_valid), .o_ready(o_ready),
    .o_data(o_data), .o_idx(o_idx), .o_last(o_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 o_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Reference requant: floor division of (x + half) by 2^sh, then clamp.
  function automatic longint rq(longint x, int sh, bit relu);
    longint r, d, n;
    if (sh == 0) r = x;
    else begin
      d = longint'(1) << sh;
      n = x + d / 2;
      r = n / d;
      if ((n % d) != 0 && n < 0) r = r - 1;
    end
    if (relu && r < 0) r = 0;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (stalled) begin
        tests_run++;
        if (o_data !== prev_data || o_idx !== prev_idx) begin
          tests_failed++;
          $display("FAIL stall_hold: data=%0d idx=%0d, held data=%0d idx=%0d", o_data, o_idx, prev_data, prev_idx);
        end
      end
      if (o_valid && o_ready) begin
        tests_run++;
        if (q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_word: data=%0d idx=%0d, no word expected", o_data, o_idx);
        end else begin
          e = q.pop_front();
          if (longint'(o_data) != e.data || int'(o_idx) != e.idx || o_last !== e.last) begin
            tests_failed++;
            $display("FAIL word: got data=%0d idx=%0d last=%0b, expected data=%0d idx=%0d last=%0b",
                     o_data, o_idx, o_last, e.data, e.idx, e.last);
          end
        end
      end
      stalled   = o_valid && !o_ready;
      prev_data = o_data;
      prev_idx  = o_idx;
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic check(string name, longint got, longint exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic pack(sums_t s);
    for (int k = 0; k < NCOL; k++) i_sum[k*2*DW +: 2*DW] = s[k];
  endtask

  task automatic beat(bit first, bit last, sums_t s, longint bias, int sh, bit relu);
    int t;
    @(posedge clk); #1;
    in_valid = 1'b1; in_first = first; in_last = last;
    pack(s);
    i_bias = AW'(bias); i_shift = SHW'(sh); i_relu = relu;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) check("beat_accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    for (int k = 0; k < NCOL; k++) macc[k] = (first ? bias : macc[k]) + longint'(s[k]);
    if (last) begin
      for (int k = 0; k < NCOL; k++) q.push_back('{rq(macc[k], sh, relu), k, k == NCOL-1});
      for (int k = 0; k < NCOL; k++) macc[k] = 0;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((q.size() != 0 || !in_ready) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("drain_timeout", q.size(), 0);
  endtask

  task automatic fill(output sums_t s, input int v);
    for (int k = 0; k < NCOL; k++) s[k] = v;
  endtask

  initial begin
    sums_t s, s2;
    int nch, sh, t;
    bit relu;
    longint bias;

    for (int k = 0; k < NCOL; k++) macc[k] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_o_valid", o_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_outputs", {o_data, o_idx, o_last}, 0);

    // Single channel, sums k*256 >> 8 -> k
    for (int k = 0; k < NCOL; k++) s[k] = k * 256;
    beat(1, 1, s, 0, 8, 0);
    wait_drain();

    // Three channels of 100 plus bias 10, with in_ready low through the drain
    fill(s, 100);
    beat(1, 0, s, 10, 0, 0);
    beat(0, 0, s, 10, 0, 0);
    beat(0, 1, s, 10, 0, 0);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      check("in_ready_low_in_drain", in_ready, 0);
    end
    @(negedge clk);
    check("in_ready_after_drain", in_ready, 1);
    wait_drain();

    // Saturation and ReLU
    fill(s, -1_000_000);
    beat(1, 1, s, 0, 0, 0);
    wait_drain();
    beat(1, 1, s, 0, 0, 1);
    wait_drain();
    fill(s, 1_000_000);
    beat(1, 1, s, 0, 0, 0);
    wait_drain();

    // Rounding boundaries
    for (int k = 0; k < NCOL; k++) s[k] = $urandom_range(0, 200000) - 100000;
    s[0] = 384; s[1] = 383; s[2] = -384; s[3] = -383; s[4] = 128; s[5] = -128;
    beat(1, 1, s, 0, 8, 0);
    wait_drain();

    // Random multi-channel passes under random backpressure
    rnd_ready = 1'b1;
    for (int p = 0; p < 6; p++) begin
      nch  = $urandom_range(1, 4);
      sh   = $urandom_range(0, 24);
      relu = 1'($urandom_range(0, 1));
      bias = longint'($signed($urandom)) * $urandom_range(1, 64);
      for (int c = 0; c < nch; c++) begin
        for (int k = 0; k < NCOL; k++) s[k] = int'($urandom);
        beat(c == 0, c == nch - 1, s, bias, sh, relu);
      end
      wait_drain();
    end

    // Beats offered during a drain must be ignored
    fill(s, 5000);
    beat(1, 1, s, 77, 0, 0);
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int k = 0; k < NCOL; k++) s2[k] = int'($urandom_range(1, 30000));
    pack(s2);
    repeat (6) @(posedge clk);
    #1 in_valid = 1'b0;
    wait_drain();
    for (int k = 0; k < NCOL; k++) s[k] = k * 3 - 20;
    beat(0, 1, s, 999, 0, 0);
    wait_drain();
    rnd_ready = 1'b0;

    // Reset in the middle of a drain
    fill(s, 2000);
    beat(1, 1, s, 300, 0, 0);
    t = 0;
    while (!(o_valid && o_idx == 4'd5) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("reach_word5", t < 100, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    q.delete();
    for (int k = 0; k < NCOL; k++) macc[k] = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_drain_o_valid", o_valid, 0);
    check("rst_mid_drain_in_ready", in_ready, 1);
    for (int k = 0; k < NCOL; k++) s[k] = 40 * k + 1;
    beat(0, 1, s, 0, 0, 0);
    wait_drain();
    beat(1, 1, s, -500, 0, 0);
    wait_drain();

    check("queue_empty_at_end", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
